// File: rtl/eu_icon_port_ctrl_pkg.sv
// Shared types and constants for the EU interconnect port controller.
// Defines the interconnect packet layout and a small width helper.
package exec_unit_dtypes;

    localparam int ICON_EU_IDX_W = 3;
    localparam int ICON_OPX_W    = 1;
    localparam int ICON_DATA_W   = 32;

    typedef struct packed {
        logic [ICON_EU_IDX_W-1:0] eu_idx;
        logic [ICON_OPX_W-1:0]    opx;
        logic [ICON_DATA_W-1:0]   data;
    } type_icon_pkt;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eu_icon_port_ctrl_if.sv
// Interface bundling the RX channels, operand slots and TX path.
// slave: the port controller; master: the EU plus fabric around it.
interface eu_icon_port_ctrl_if
    import exec_unit_dtypes::*;
#(
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_OPERANDS   = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int EU_IDX_W       = ICON_EU_IDX_W,
    parameter int LOG2_TXQ_DEPTH = 2,
    parameter int OPX_W          = clog2_min1(NUM_OPERANDS)
);

    logic [NUM_CHANNELS-1:0]            ch_valid_i;
    logic [NUM_CHANNELS*EU_IDX_W-1:0]   ch_eu_idx_i;
    logic [NUM_CHANNELS*OPX_W-1:0]      ch_opx_i;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data_i;
    logic [NUM_CHANNELS-1:0]            ch_ready_o;

    logic [NUM_OPERANDS-1:0]            op_valid_o;
    logic [NUM_OPERANDS*DATA_WIDTH-1:0] op_data_o;
    logic [NUM_OPERANDS-1:0]            op_ready_i;

    logic                               tx_wvalid_i;
    logic [EU_IDX_W-1:0]                tx_eu_idx_i;
    logic [OPX_W-1:0]                   tx_opx_i;
    logic [DATA_WIDTH-1:0]              tx_wdata_i;
    logic                               tx_full_o;
    logic [LOG2_TXQ_DEPTH:0]            txq_count_o;

    logic                               out_valid_o;
    logic [EU_IDX_W-1:0]                out_eu_idx_o;
    logic [OPX_W-1:0]                   out_opx_o;
    logic [DATA_WIDTH-1:0]              out_data_o;
    logic                               out_ready_i;

    modport slave (
        input  ch_valid_i, ch_eu_idx_i, ch_opx_i, ch_data_i,
        input  op_ready_i,
        input  tx_wvalid_i, tx_eu_idx_i, tx_opx_i, tx_wdata_i,
        input  out_ready_i,
        output ch_ready_o, op_valid_o, op_data_o,
        output tx_full_o, txq_count_o,
        output out_valid_o, out_eu_idx_o, out_opx_o, out_data_o
    );

    modport master (
        output ch_valid_i, ch_eu_idx_i, ch_opx_i, ch_data_i,
        output op_ready_i,
        output tx_wvalid_i, tx_eu_idx_i, tx_opx_i, tx_wdata_i,
        output out_ready_i,
        input  ch_ready_o, op_valid_o, op_data_o,
        input  tx_full_o, txq_count_o,
        input  out_valid_o, out_eu_idx_o, out_opx_o, out_data_o
    );

endinterface

// File: rtl/eu_icon_port_ctrl_tx_fifo.sv
// First-word-fall-through FIFO with occupancy count, async active-high reset.
// Ports: push/push_data/full/count (write), pop_ready/head_valid/head_data (read).
module icon_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  full,
    output logic [LOG2_DEPTH:0]   count,
    input  logic                  pop_ready,
    output logic                  head_valid,
    output logic [WIDTH-1:0]      head_data
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   cnt;
    logic                  do_push;
    logic                  do_pop;

    // Full comes from the registered count, so a push while full is
    // refused even when a pop happens in the same cycle.
    assign full       = (cnt == (LOG2_DEPTH+1)'(DEPTH));
    assign head_valid = (cnt != '0);
    assign head_data  = mem[rd_ptr];
    assign count      = cnt;
    assign do_push    = push && !full;
    assign do_pop     = head_valid && pop_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (!do_push && do_pop)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/eu_icon_port_ctrl.sv
// EU interconnect port: per-operand capture slots fed from broadcast
// channels, and a TX FIFO onto the outbound channel.
// Ports: clk, reset (async, active high), bus (eu_icon_port_ctrl_if.slave).
// Build option ICON_RR_ARB_EN: round-robin channel arbitration per slot;
// without it each slot uses fixed lowest-channel-first priority.
module eu_icon_port_ctrl
    import exec_unit_dtypes::*;
#(
    parameter int EU_IDX         = 0,
    parameter int NUM_CHANNELS   = 4,
    parameter int NUM_OPERANDS   = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int EU_IDX_W       = ICON_EU_IDX_W,
    parameter int LOG2_TXQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    eu_icon_port_ctrl_if.slave   bus
);

    localparam int OPX_W = clog2_min1(NUM_OPERANDS);
    localparam int CH_W  = clog2_min1(NUM_CHANNELS);
    localparam int PKT_W = EU_IDX_W + OPX_W + DATA_WIDTH;

    logic [NUM_CHANNELS-1:0][EU_IDX_W-1:0]   ch_eu;
    logic [NUM_CHANNELS-1:0][OPX_W-1:0]      ch_opx;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data;
    logic [NUM_OPERANDS-1:0][NUM_CHANNELS-1:0] grant;
    logic [NUM_OPERANDS-1:0]                   slot_valid;
    logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]   slot_data;
    logic [NUM_CHANNELS-1:0]                   ready;

    assign ch_eu   = bus.ch_eu_idx_i;
    assign ch_opx  = bus.ch_opx_i;
    assign ch_data = bus.ch_data_i;

    for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_slot
        logic [NUM_CHANNELS-1:0] hit;
        logic [CH_W-1:0]         ptr;
        logic [CH_W-1:0]         idx;
        logic [CH_W-1:0]         win;
        logic                    found;
        logic                    accept;
        logic                    load;
        logic                    valid_q;
        logic [DATA_WIDTH-1:0]   data_q;

        // An opx outside the slot range matches no k, so it never hits.
        for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_hit
            assign hit[c] = bus.ch_valid_i[c]
                         && (ch_eu[c] == EU_IDX_W'(EU_IDX))
                         && (ch_opx[c] == OPX_W'(k));
        end

        // Scan channels starting at ptr; first hit wins.
        always_comb begin
            found = 1'b0;
            win   = '0;
            idx   = '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                idx = CH_W'((int'(ptr) + i) % NUM_CHANNELS);
                if (!found && hit[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end

        assign accept   = !valid_q || bus.op_ready_i[k];
        assign load     = found && accept && !reset;
        assign grant[k] = load ? (NUM_CHANNELS'(1) << win) : '0;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (load) begin
                valid_q <= 1'b1;
                data_q  <= ch_data[win];
            end else if (bus.op_ready_i[k]) begin
                valid_q <= 1'b0;
            end
        end

`ifdef ICON_RR_ARB_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                ptr <= '0;
            else if (load)
                ptr <= (win == CH_W'(NUM_CHANNELS - 1)) ? '0 : win + 1'b1;
        end
`else
        assign ptr = '0;
`endif

        assign slot_valid[k] = valid_q;
        assign slot_data[k]  = data_q;
    end

    // Each channel targets a single operand, so OR-ing is collision free.
    always_comb begin
        ready = '0;
        for (int k = 0; k < NUM_OPERANDS; k++)
            ready = ready | grant[k];
    end

    assign bus.ch_ready_o = ready;
    assign bus.op_valid_o = slot_valid;
    assign bus.op_data_o  = slot_data;

    logic [PKT_W-1:0] push_pkt;
    logic [PKT_W-1:0] head_pkt;

    assign push_pkt = {bus.tx_eu_idx_i, bus.tx_opx_i, bus.tx_wdata_i};

    icon_tx_fifo #(
        .WIDTH      (PKT_W),
        .LOG2_DEPTH (LOG2_TXQ_DEPTH)
    ) u_txq (
        .clk        (clk),
        .reset      (reset),
        .push       (bus.tx_wvalid_i),
        .push_data  (push_pkt),
        .full       (bus.tx_full_o),
        .count      (bus.txq_count_o),
        .pop_ready  (bus.out_ready_i),
        .head_valid (bus.out_valid_o),
        .head_data  (head_pkt)
    );

    assign {bus.out_eu_idx_o, bus.out_opx_o, bus.out_data_o} = head_pkt;

endmodule
